// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch-side types: FSM state encoding, the buffered fetch entry
// layout, the NOP word shown while nothing is buffered, and an
// address-alignment helper.
package instruction_fetch_queue_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int          ENTRY_W   = $bits(fetch_entry_t);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction fetches are word sized; drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding {pc, instr} fetch entries.
// Flush empties the queue and wins over a push or pop in the same cycle.
// The head is read straight from storage, so a pushed entry becomes
// visible the cycle after it is written.
module instruction_fetch_queue_fetch_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [ENTRY_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               do_push;
  logic               do_pop;

  // The full/empty guards only protect the pointers; the producer's credit
  // check already keeps pushes away from a full queue.
  assign do_push = push && !flush && (count_q != CW'(DEPTH));
  assign do_pop  = pop  && !flush && (count_q != '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Entry storage: plain data registers, no reset needed since count gates use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, flush clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: owns the PC, issues sequential word fetches to a
// 1-cycle-latency instruction memory, buffers {pc, instr} pairs and hands
// them to decode over valid/ready. A redirect squashes buffered and
// in-flight fetches and restarts at the (word-aligned) target.
// Optional build macro FETCH_PERF_COUNTERS_EN adds delivered/squashed
// counters; without it both counter ports read zero.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        iClk,
  input  logic        iRstN,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic [31:0] iImemData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oInstruction,
  output logic [31:0] oPC,
  output logic [31:0] oFetchCount,
  output logic [31:0] oSquashCount
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t       state_q;
  logic [31:0]        pc_q;
  logic [31:0]        req_pc_q;
  logic               inflight_q;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] head_data;
  fetch_entry_t       head_entry;
  fetch_entry_t       push_entry;
  logic               credit_ok;
  logic               push;
  logic               pop;

  // Count the outstanding request as occupied so its response always has a slot.
  assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < 32'(DEPTH);
  assign oImemReq  = (state_q != BOOT) && !iRedirect && credit_ok;
  assign oImemAddr = pc_q;

  // Responses landing in FLUSH belong to the squashed stream.
  assign push       = inflight_q && (state_q == FETCH);
  assign pop        = oValid && iReady && !iRedirect;
  assign push_entry = '{pc: req_pc_q, instr: iImemData};

  assign oValid       = (fifo_count != '0);
  assign head_entry   = fetch_entry_t'(head_data);
  assign oInstruction = oValid ? head_entry.instr : NOP_INSTR;
  assign oPC          = oValid ? head_entry.pc    : RESET_PC;

  instruction_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (iClk),
    .rst_n     (iRstN),
    .push      (push),
    .pop       (pop),
    .flush     (iRedirect),
    .push_data (push_entry),
    .count     (fifo_count),
    .head      (head_data)
  );

  // Fetch FSM: state, PC, and the PC/valid of the request now in flight.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= oImemReq;
      if (oImemReq) req_pc_q <= pc_q;
      if (iRedirect) begin
        pc_q    <= word_align(iRedirectPC);
        state_q <= FLUSH;
      end else begin
        if (oImemReq) pc_q <= pc_q + PC_STEP;
        case (state_q)
          BOOT:    state_q <= FETCH;
          FETCH:   state_q <= FETCH;
          FLUSH:   state_q <= FETCH;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] squash_count_q;

  // Delivered count per pop; squash count adds flushed entries plus the lost response.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      if (pop) fetch_count_q <= fetch_count_q + 32'd1;
      if (iRedirect) begin
        squash_count_q <= squash_count_q + 32'(fifo_count) + 32'(inflight_q);
      end
    end
  end

  assign oFetchCount  = fetch_count_q;
  assign oSquashCount = squash_count_q;
`else
  assign oFetchCount  = 32'd0;
  assign oSquashCount = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: memory returns word == address one
// cycle after each request; a scoreboard queue of expected PCs is loaded
// whenever the bench releases reset or drives a redirect, and is popped on
// every handshake at the decode port.
`timescale 1ns/1ps
module tb_instruction_fetch_queue;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic [31:0] iImemData;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstruction;
  logic [31:0] oPC;
  logic [31:0] oFetchCount;
  logic [31:0] oSquashCount;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC  = 32'h0000_0000;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  int          delivered;
  logic [31:0] exp_squash;
  logic [31:0] squash_add;
  logic        pending_req;
  logic [31:0] pending_addr;

  instruction_fetch_queue dut (
    .iClk         (iClk),
    .iRstN        (iRstN),
    .oImemReq     (oImemReq),
    .oImemAddr    (oImemAddr),
    .iImemData    (iImemData),
    .iRedirect    (iRedirect),
    .iRedirectPC  (iRedirectPC),
    .oValid       (oValid),
    .iReady       (iReady),
    .oInstruction (oInstruction),
    .oPC          (oPC),
    .oFetchCount  (oFetchCount),
    .oSquashCount (oSquashCount)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected delivery stream starting at a (word-aligned) base address.
  task automatic refill(input logic [31:0] base);
    logic [31:0] b;
    b = base & 32'hFFFF_FFFC;
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(b + 32'(i) * 32'd4);
  endtask

  // Negedge observation: counters, head against scoreboard, memory capture.
  task automatic at_neg();
    @(negedge iClk);
    check("fetch_cnt", oFetchCount, PERF ? 32'(delivered) : 32'd0);
    check("squash_cnt", oSquashCount, PERF ? exp_squash : 32'd0);
    if (oValid) begin
      check("sb_avail", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check("head_pc", oPC, sb_q[0]);
        check("head_instr", oInstruction, sb_q[0]);
        if (iReady && !iRedirect) begin
          $display("[TB] deliver pc=%h instr=%h", oPC, oInstruction);
          void'(sb_q.pop_front());
          delivered++;
        end
      end
    end
    if (iRedirect) begin
      $display("[TB] redirect to %h", iRedirectPC);
      refill(iRedirectPC);
      exp_squash = exp_squash + squash_add;
    end
    pending_req  = oImemReq;
    pending_addr = oImemAddr;
  endtask

  // Advance past the active edge and present the memory response.
  task automatic to_pos();
    @(posedge iClk);
    #1;
    iImemData = pending_req ? pending_addr : 32'hDEAD_BEEF;
  endtask

  initial begin
    iRstN        = 1'b0;
    iReady       = 1'b1;
    iRedirect    = 1'b0;
    iRedirectPC  = 32'd0;
    iImemData    = 32'hDEAD_BEEF;
    squash_add   = 32'd0;
    exp_squash   = 32'd0;
    delivered    = 0;
    pending_req  = 1'b0;
    pending_addr = 32'd0;
    refill(BOOT_PC);

    // Reset values
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("rst_req", 32'(oImemReq), 32'd0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_instr", oInstruction, NOP_WORD);
    check("rst_pc", oPC, BOOT_PC);
    check("rst_fcnt", oFetchCount, 32'd0);
    check("rst_scnt", oSquashCount, 32'd0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;

    // Startup latency and streaming
    for (int k = 0; k < 8; k++) begin
      at_neg();
      check("s1_req", 32'(oImemReq), 32'(k >= 1));
      if (k >= 1) check("s1_addr", oImemAddr, 32'(k - 1) * 32'd4);
      check("s1_valid", 32'(oValid), 32'(k >= 3));
      to_pos();
    end

    // Asynchronous reset pulse mid-stream
    #2;
    iRstN = 1'b0;
    #1;
    check("rp_valid", 32'(oValid), 32'd0);
    check("rp_req", 32'(oImemReq), 32'd0);
    check("rp_pc", oPC, BOOT_PC);
    refill(BOOT_PC);
    delivered   = 0;
    exp_squash  = 32'd0;
    pending_req = 1'b0;
    @(posedge iClk);
    #1;
    iRstN     = 1'b1;
    iImemData = 32'hDEAD_BEEF;

    // Restart, then stall decode for 10 cycles and release
    for (int k = 0; k <= 20; k++) begin
      iReady = !(k >= 3 && k <= 12);
      at_neg();
      if (k < 3) check("s2_valid_lo", 32'(oValid), 32'd0);
      if (k == 1) check("s2_req0", 32'(oImemReq), 32'd1);
      if (k == 1) check("s2_addr0", oImemAddr, BOOT_PC);
      if (k == 3) check("s2_first_pc", oPC, BOOT_PC);
      if (k >= 3) check("s2_valid", 32'(oValid), 32'd1);
      if (k >= 6 && k <= 12) check("s2_req_full", 32'(oImemReq), 32'd0);
      if (k == 12) check("s2_hold_pc", oImemAddr, 32'h10);
      to_pos();
    end

    // Redirect with 3 buffered entries and one request in flight
    iReady = 1'b0;
    at_neg();
    to_pos();
    iReady      = 1'b1;
    iRedirect   = 1'b1;
    iRedirectPC = 32'h100;
    squash_add  = 32'd4;
    at_neg();
    to_pos();
    iRedirect = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      at_neg();
      check("s3_valid", 32'(oValid), 32'(j >= 3));
      if (j == 1) check("s3_addr", oImemAddr, 32'h100);
      if (j == 3) check("s3_pc", oPC, 32'h100);
      to_pos();
    end

    // Back-to-back redirects: last one wins
    iRedirect   = 1'b1;
    iRedirectPC = 32'h200;
    squash_add  = 32'd2;
    at_neg();
    to_pos();
    iRedirectPC = 32'h300;
    squash_add  = 32'd0;
    at_neg();
    to_pos();
    iRedirect = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      at_neg();
      check("s4_valid", 32'(oValid), 32'(j >= 3));
      if (j == 1) check("s4_addr", oImemAddr, 32'h300);
      if (j == 3) check("s4_pc", oPC, 32'h300);
      to_pos();
    end

    // Unaligned redirect target
    iRedirect   = 1'b1;
    iRedirectPC = 32'h103;
    squash_add  = 32'd2;
    at_neg();
    to_pos();
    iRedirect = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      at_neg();
      if (j == 1) check("s5_addr", oImemAddr, 32'h100);
      if (j == 3) check("s5_pc", oPC, 32'h100);
      to_pos();
    end

    // PC wrap at the top of the address space
    iRedirect   = 1'b1;
    iRedirectPC = 32'hFFFF_FFFE;
    squash_add  = 32'd2;
    at_neg();
    to_pos();
    iRedirect = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      at_neg();
      if (j == 1) check("s6_addr_top", oImemAddr, 32'hFFFF_FFFC);
      if (j == 2) check("s6_addr_wrap", oImemAddr, 32'h0000_0000);
      if (j == 3) check("s6_pc_top", oPC, 32'hFFFF_FFFC);
      if (j == 4) check("s6_pc_wrap", oPC, 32'h0000_0000);
      to_pos();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
